// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential binary-to-BCD converter (shift-and-add-3, one bit
//               per clock) with start/busy/done handshake and overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [W-1:0]        bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                overflow
);
    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_CNT_W = $clog2(W + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [W-1:0]         r_shift;
    logic [c_BCD_W-1:0]   r_work;
    logic [c_BCD_W-1:0]   r_bcd;
    logic [c_BCD_W-1:0]   w_adj;
    logic [c_BCD_W-1:0]   w_work_next;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_ovf_acc;
    logic                 r_done;
    logic                 r_overflow;
    logic                 w_bit_out;
    logic                 w_last;

    // Digits >= 5 get +3 so the following left shift carries into the next digit.
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            assign w_adj[4*i +: 4] = (r_work[4*i +: 4] >= 4'd5) ?
                                     (r_work[4*i +: 4] + 4'd3) : r_work[4*i +: 4];
        end
    endgenerate

    assign w_work_next = {w_adj[c_BCD_W-2:0], r_shift[W-1]};
    assign w_bit_out   = w_adj[c_BCD_W-1];
    assign w_last      = (r_state == S_CONV) && (r_count == c_CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CONV;
            S_CONV:  if (w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift    <= '0;
            r_work     <= '0;
            r_count    <= '0;
            r_ovf_acc  <= 1'b0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift   <= bin;
                        r_work    <= '0;
                        r_ovf_acc <= 1'b0;
                        r_count   <= c_CNT_W'(W);
                    end
                end
                S_CONV: begin
                    r_work    <= w_work_next;
                    r_shift   <= r_shift << 1;
                    r_ovf_acc <= r_ovf_acc | w_bit_out;
                    r_count   <= r_count - c_CNT_W'(1);
                    // Results are only published on the final shift so they hold
                    // their previous value throughout a conversion.
                    if (w_last) begin
                        r_bcd      <= w_work_next;
                        r_overflow <= r_ovf_acc | w_bit_out;
                        r_done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state == S_CONV);
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2bcd_seq
// Description : Scoreboard bench for bin2bcd_seq (W=8/D=3 and W=10/D=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start_a, busy_a, done_a, ovf_a;
    logic [7:0] bin_a;
    logic [11:0] bcd_a;
    logic       start_b, busy_b, done_b, ovf_b;
    logic [9:0] bin_b;
    logic [7:0] bcd_b;

    bin2bcd_seq #(.W(8), .DIGITS(3)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .bin(bin_a),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a)
    );

    bin2bcd_seq #(.W(10), .DIGITS(2)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .bin(bin_b),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b)
    );

    typedef struct packed { logic [11:0] bcd; logic ovf; } exp_a_t;
    typedef struct packed { logic [7:0]  bcd; logic ovf; } exp_b_t;

    exp_a_t q_a[$];
    exp_b_t q_b[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_a_t mk_a(input logic [11:0] b, input logic o);
        exp_a_t e;
        e.bcd = b;
        e.ovf = o;
        return e;
    endfunction

    function automatic exp_b_t mk_b(input logic [7:0] b, input logic o);
        exp_b_t e;
        e.bcd = b;
        e.ovf = o;
        return e;
    endfunction

    // Reference: decimal digits of v mod 1000 via div/mod.
    function automatic exp_a_t model_a(input int v);
        int m;
        m = v % 1000;
        return mk_a({4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)}, v > 999);
    endfunction

    always @(negedge clk) begin
        if (done_a === 1'b1) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done_a: got bcd %0h with empty scoreboard", bcd_a);
            end else begin
                exp_a_t e;
                e = q_a.pop_front();
                check("bcd_a", 32'(bcd_a), 32'(e.bcd));
                check("ovf_a", 32'(ovf_a), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (done_b === 1'b1) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done_b: got bcd %0h with empty scoreboard", bcd_b);
            end else begin
                exp_b_t e;
                e = q_b.pop_front();
                check("bcd_b", 32'(bcd_b), 32'(e.bcd));
                check("ovf_b", 32'(ovf_b), 32'(e.ovf));
            end
        end
    end

    task automatic wait_idle_a();
        int n = 0;
        @(negedge clk);
        while (busy_a && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("timeout_idle_a", 32'(busy_a), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_idle_b();
        int n = 0;
        @(negedge clk);
        while (busy_b && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("timeout_idle_b", 32'(busy_b), 32'd0);
        @(negedge clk);
    endtask

    task automatic conv_a(input logic [7:0] v, input exp_a_t e);
        wait_idle_a();
        bin_a   = v;
        start_a = 1'b1;
        q_a.push_back(e);
        @(negedge clk);
        start_a = 1'b0;
        bin_a   = ~v;
    endtask

    task automatic conv_b(input logic [9:0] v, input exp_b_t e);
        wait_idle_b();
        bin_b   = v;
        start_b = 1'b1;
        q_b.push_back(e);
        @(negedge clk);
        start_b = 1'b0;
        bin_b   = ~v;
    endtask

    task automatic wait_done_a();
        int n = 0;
        while (!done_a && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("timeout_done_a", 32'(done_a), 32'd1);
    endtask

    initial begin
        int t0, t1, t2, nb, nd;
        logic [11:0] prev;
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        bin_a   = '0;
        bin_b   = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_bcd",  32'(bcd_a),  32'd0);
        check("rst_ovf",  32'(ovf_a),  32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Accept-to-done latency for W=8 is 9 edges.
        bin_a   = 8'd0;
        start_a = 1'b1;
        q_a.push_back(mk_a(12'h000, 1'b0));
        t0 = cyc;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a();
        check("latency_a", 32'(cyc - t0), 32'd9);

        conv_a(8'd255, mk_a(12'h255, 1'b0));
        conv_a(8'd99,  mk_a(12'h099, 1'b0));
        conv_a(8'd128, mk_a(12'h128, 1'b0));
        conv_a(8'd9,   mk_a(12'h009, 1'b0));

        conv_b(10'd999,  mk_b(8'h99, 1'b1));
        conv_b(10'd100,  mk_b(8'h00, 1'b1));
        conv_b(10'd57,   mk_b(8'h57, 1'b0));
        conv_b(10'd99,   mk_b(8'h99, 1'b0));
        conv_b(10'd1023, mk_b(8'h23, 1'b1));
        wait_idle_b();

        // Start during busy must be ignored; result held until done.
        wait_idle_a();
        prev    = bcd_a;
        bin_a   = 8'd37;
        start_a = 1'b1;
        q_a.push_back(mk_a(12'h037, 1'b0));
        nb = 0;
        nd = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) start_a = 1'b0;
            if (k == 3) begin start_a = 1'b1; bin_a = 8'd200; end
            if (k == 4) begin
                start_a = 1'b0;
                check("bcd_hold", 32'(bcd_a), 32'(prev));
            end
            nb += int'(busy_a);
            nd += int'(done_a);
        end
        check("busy_cycles", 32'(nb), 32'd8);
        check("done_pulses", 32'(nd), 32'd1);

        // Continuous start: back-to-back conversions every 9 cycles.
        wait_idle_a();
        bin_a   = 8'd12;
        start_a = 1'b1;
        q_a.push_back(mk_a(12'h012, 1'b0));
        @(negedge clk);
        bin_a = 8'd200;
        q_a.push_back(mk_a(12'h200, 1'b0));
        wait_done_a();
        t1 = cyc;
        @(negedge clk);
        wait_done_a();
        t2 = cyc;
        start_a = 1'b0;
        check("b2b_period", 32'(t2 - t1), 32'd9);

        // Asynchronous reset mid-conversion aborts without a done pulse.
        wait_idle_a();
        bin_a   = 8'd77;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy_a), 32'd0);
        check("arst_done", 32'(done_a), 32'd0);
        check("arst_bcd",  32'(bcd_a),  32'd0);
        check("arst_ovf",  32'(ovf_a),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        conv_a(8'd77, mk_a(12'h077, 1'b0));

        for (int v = 0; v < 256; v++) begin
            conv_a(8'(v), model_a(v));
        end

        wait_idle_a();
        wait_idle_b();
        check("queue_a_drained", 32'(q_a.size()), 32'd0);
        check("queue_b_drained", 32'(q_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
